// File: rtl/hdmi_pattern_gen.sv
// rtl/hdmi_pattern_gen.sv - 1080p60 raster timing and RGB test pattern source
module hdmi_pattern_gen #(
    parameter int X_WIDTH = 12,
    parameter int Y_WIDTH = 12,
    parameter int H_TOTAL = 2200,
    parameter int H_SYNC  = 44,
    parameter int H_BP    = 148,
    parameter int H_ACT   = 1920,
    parameter int H_FP    = 88,
    parameter int V_TOTAL = 1125,
    parameter int V_SYNC  = 5,
    parameter int V_BP    = 36,
    parameter int V_ACT   = 1080,
    parameter int V_FP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         pattern_sel,
    output logic               vs_out,
    output logic               hs_out,
    output logic               de_out,
    output logic [7:0]         r_out,
    output logic [7:0]         g_out,
    output logic [7:0]         b_out,
    output logic [X_WIDTH-1:0] x_act,
    output logic [Y_WIDTH-1:0] y_act,
    output logic               frame_start
);

    localparam int BAR_W = H_ACT / 8;

    localparam logic [X_WIDTH-1:0] H_LAST = X_WIDTH'(H_TOTAL - 1);
    localparam logic [X_WIDTH-1:0] HS_END = X_WIDTH'(H_SYNC);
    localparam logic [X_WIDTH-1:0] HA_BEG = X_WIDTH'(H_SYNC + H_BP);
    localparam logic [X_WIDTH-1:0] HA_END = X_WIDTH'(H_SYNC + H_BP + H_ACT);

    localparam logic [Y_WIDTH-1:0] V_LAST = Y_WIDTH'(V_TOTAL - 1);
    localparam logic [Y_WIDTH-1:0] VS_END = Y_WIDTH'(V_SYNC);
    localparam logic [Y_WIDTH-1:0] VA_BEG = Y_WIDTH'(V_SYNC + V_BP);
    localparam logic [Y_WIDTH-1:0] VA_END = Y_WIDTH'(V_SYNC + V_BP + V_ACT);

    if (H_SYNC + H_BP + H_ACT + H_FP != H_TOTAL) begin : g_bad_h
        $error("horizontal timing terms do not sum to H_TOTAL");
    end
    if (V_SYNC + V_BP + V_ACT + V_FP != V_TOTAL) begin : g_bad_v
        $error("vertical timing terms do not sum to V_TOTAL");
    end
    if (H_ACT % 8 != 0) begin : g_bad_bars
        $error("H_ACT must be divisible by 8");
    end

    logic [X_WIDTH-1:0] h_cnt;
    logic [Y_WIDTH-1:0] v_cnt;
    logic [7:0]         frame_cnt;
    logic [1:0]         pat_q;

    logic               frame_top;
    logic               de_d;
    logic [X_WIDTH-1:0] x_d;
    logic [Y_WIDTH-1:0] y_d;
    logic [2:0]         bar_idx;
    logic [23:0]        rgb_d;

    assign frame_top = (h_cnt == '0) && (v_cnt == '0);
    assign de_d      = (h_cnt >= HA_BEG) && (h_cnt < HA_END) &&
                       (v_cnt >= VA_BEG) && (v_cnt < VA_END);
    assign x_d       = h_cnt - HA_BEG;
    assign y_d       = v_cnt - VA_BEG;

    // Bar index by threshold compare rather than a divider by H_ACT/8.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_d >= X_WIDTH'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        rgb_d = 24'h000000;
        if (de_d) begin
            case (pat_q)
                2'd0: begin
                    case (bar_idx)
                        3'd0:    rgb_d = 24'hFFFFFF;
                        3'd1:    rgb_d = 24'hFFFF00;
                        3'd2:    rgb_d = 24'h00FFFF;
                        3'd3:    rgb_d = 24'h00FF00;
                        3'd4:    rgb_d = 24'hFF00FF;
                        3'd5:    rgb_d = 24'hFF0000;
                        3'd6:    rgb_d = 24'h0000FF;
                        default: rgb_d = 24'h000000;
                    endcase
                end
                2'd1:    rgb_d = {3{x_d[10:3]}};
                2'd2:    rgb_d = ((x_d[5:0] == 6'd0) || (y_d[5:0] == 6'd0)) ?
                                 24'hFFFFFF : 24'h000000;
                default: rgb_d = {frame_cnt, ~frame_cnt, 8'h80};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_cnt   <= 8'd0;
            pat_q       <= 2'd0;
            vs_out      <= 1'b0;
            hs_out      <= 1'b0;
            de_out      <= 1'b0;
            r_out       <= 8'd0;
            g_out       <= 8'd0;
            b_out       <= 8'd0;
            x_act       <= '0;
            y_act       <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            // Idle: restart from the top of a frame once enabled again.
            h_cnt       <= '0;
            v_cnt       <= '0;
            vs_out      <= 1'b0;
            hs_out      <= 1'b0;
            de_out      <= 1'b0;
            r_out       <= 8'd0;
            g_out       <= 8'd0;
            b_out       <= 8'd0;
            x_act       <= '0;
            y_act       <= '0;
            frame_start <= 1'b0;
        end else begin
            if (frame_top) begin
                pat_q     <= pattern_sel;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            vs_out      <= v_cnt < VS_END;
            hs_out      <= h_cnt < HS_END;
            de_out      <= de_d;
            r_out       <= rgb_d[23:16];
            g_out       <= rgb_d[15:8];
            b_out       <= rgb_d[7:0];
            x_act       <= de_d ? x_d : '0;
            y_act       <= de_d ? y_d : '0;
            frame_start <= frame_top;
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb/tb_hdmi_pattern_gen.sv - scoreboard bench for hdmi_pattern_gen
module tb_hdmi_pattern_gen;

    typedef struct {
        int hs, hb, ha, ht, vs, vb, va, vt;
    } tim_t;

    typedef struct packed {
        logic       vs, hs, de, fs;
        logic [7:0] r, g, b;
        logic [11:0] x, y;
    } vid_t;

    localparam int A_HS = 8, A_HB = 8, A_HA = 1024, A_HF = 8, A_HT = 1048;
    localparam int A_VS = 1, A_VB = 1, A_VA = 2,    A_VF = 1, A_VT = 5;
    localparam int A_F  = A_HT * A_VT;
    localparam int B_HS = 2, B_HB = 2, B_HA = 8, B_HF = 8, B_HT = 20;
    localparam int B_VS = 1, B_VB = 1, B_VA = 4, B_VF = 4, B_VT = 10;
    localparam int B_F  = B_HT * B_VT;

    tim_t ta = '{A_HS, A_HB, A_HA, A_HT, A_VS, A_VB, A_VA, A_VT};
    tim_t tb = '{B_HS, B_HB, B_HA, B_HT, B_VS, B_VB, B_VA, B_VT};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, rst_n_b, en_b;
    logic [1:0]  pattern_sel, pattern_sel_b;
    logic        vs_a, hs_a, de_a, fs_a, vs_b, hs_b, de_b, fs_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic [11:0] x_a, y_a, x_b, y_b;

    hdmi_pattern_gen #(
        .X_WIDTH(12), .Y_WIDTH(12),
        .H_TOTAL(A_HT), .H_SYNC(A_HS), .H_BP(A_HB), .H_ACT(A_HA), .H_FP(A_HF),
        .V_TOTAL(A_VT), .V_SYNC(A_VS), .V_BP(A_VB), .V_ACT(A_VA), .V_FP(A_VF)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
        .vs_out(vs_a), .hs_out(hs_a), .de_out(de_a),
        .r_out(r_a), .g_out(g_a), .b_out(b_a),
        .x_act(x_a), .y_act(y_a), .frame_start(fs_a)
    );

    hdmi_pattern_gen #(
        .X_WIDTH(12), .Y_WIDTH(12),
        .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_BP(B_HB), .H_ACT(B_HA), .H_FP(B_HF),
        .V_TOTAL(B_VT), .V_SYNC(B_VS), .V_BP(B_VB), .V_ACT(B_VA), .V_FP(B_VF)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .pattern_sel(pattern_sel_b),
        .vs_out(vs_b), .hs_out(hs_b), .de_out(de_b),
        .r_out(r_b), .g_out(g_b), .b_out(b_b),
        .x_act(x_b), .y_act(y_b), .frame_start(fs_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference: position in the frame is a single linear index t.
    function automatic vid_t ref_pixel(tim_t p, int t, int pat, int frame);
        vid_t        o;
        int          h, v, x, y;
        logic [23:0] c;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        o = '0;
        c = 24'h0;
        h = t % p.ht;
        v = t / p.ht;
        o.vs = (v < p.vs);
        o.hs = (h < p.hs);
        o.fs = (t == 0);
        x = h - p.hs - p.hb;
        y = v - p.vs - p.vb;
        if (x >= 0 && x < p.ha && y >= 0 && y < p.va) begin
            o.de = 1'b1;
            o.x  = 12'(x);
            o.y  = 12'(y);
            case (pat)
                0:       c = bars[x / (p.ha / 8)];
                1:       c = {3{8'((x / 8) % 256)}};
                2:       c = (x % 64 == 0 || y % 64 == 0) ? 24'hFFFFFF : 24'h0;
                default: c = {8'(frame), ~8'(frame), 8'h80};
            endcase
        end
        {o.r, o.g, o.b} = c;
        return o;
    endfunction

    vid_t qa[$], qb[$];
    int   t_a = 0, fr_a = 0, pat_a = 0, abort_cnt_a = 0;
    int   t_b = 0, fr_b = 0, pat_b = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            t_a = 0; fr_a = 0; pat_a = 0; abort_cnt_a++;
            qa.push_back('0);
        end else if (!en) begin
            t_a = 0; abort_cnt_a++;
            qa.push_back('0);
        end else begin
            if (t_a == 0) begin
                pat_a = int'(pattern_sel);
                fr_a  = (fr_a + 1) % 256;
            end
            qa.push_back(ref_pixel(ta, t_a, pat_a, fr_a));
            t_a = (t_a + 1) % A_F;
        end
        if (!rst_n_b) begin
            t_b = 0; fr_b = 0; pat_b = 0;
            qb.push_back('0);
        end else if (!en_b) begin
            t_b = 0;
            qb.push_back('0);
        end else begin
            if (t_b == 0) begin
                pat_b = int'(pattern_sel_b);
                fr_b  = (fr_b + 1) % 256;
            end
            qb.push_back(ref_pixel(tb, t_b, pat_b, fr_b));
            t_b = (t_b + 1) % B_F;
        end
    end

    vid_t ea, aa, eb, ab;
    int   span_a = 0, de_acc_a = 0, abort_at_fs = 0;
    bit   seen_fs_a = 0, saw255_b = 0, wrap_seen_b = 0;

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            aa = {vs_a, hs_a, de_a, fs_a, r_a, g_a, b_a, x_a, y_a};
            checks++;
            if (aa !== ea) begin
                errors++;
                $display("FAIL pix_a t=%0t actual=%h required=%h", $time, aa, ea);
            end
            span_a++;
            if (aa.de) de_acc_a++;
            if (aa.fs) begin
                if (seen_fs_a && abort_at_fs == abort_cnt_a) begin
                    checks++;
                    if (span_a != A_F) begin
                        errors++;
                        $display("FAIL frame_period actual=%0d required=%0d", span_a, A_F);
                    end
                    checks++;
                    if (de_acc_a != A_HA * A_VA) begin
                        errors++;
                        $display("FAIL de_per_frame actual=%0d required=%0d", de_acc_a, A_HA * A_VA);
                    end
                end
                seen_fs_a   = 1;
                abort_at_fs = abort_cnt_a;
                span_a      = 0;
                de_acc_a    = 0;
            end
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            ab = {vs_b, hs_b, de_b, fs_b, r_b, g_b, b_b, x_b, y_b};
            checks++;
            if (ab !== eb) begin
                errors++;
                $display("FAIL pix_b t=%0t actual=%h required=%h", $time, ab, eb);
            end
            if (de_b && r_b == 8'hFF) saw255_b = 1;
            if (saw255_b && de_b && r_b == 8'h00) wrap_seen_b = 1;
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pattern_sel = 2'd0;
        rst_n_b = 1'b0; en_b = 1'b1; pattern_sel_b = 2'd3;
        run(5);
        rst_n = 1'b1; rst_n_b = 1'b1;

        run(A_F + 3 * A_HT);
        pattern_sel = 2'd1;
        run(A_F);
        run(A_F / 2);
        pattern_sel = 2'd2;
        run(A_F);
        pattern_sel = 2'd3;
        run(3 * A_F);

        run($urandom_range(100, A_F - 100));
        en = 1'b0;
        run($urandom_range(1, 20));
        pattern_sel = 2'($urandom_range(0, 3));
        en = 1'b1;
        run(A_F + 10);

        pattern_sel = 2'($urandom_range(1, 3));
        run(A_F + $urandom_range(100, A_F - 100));
        rst_n = 1'b0;
        run($urandom_range(1, 5));
        rst_n = 1'b1;
        run(2 * A_F + 10);

        while (cyc < 258 * B_F) @(negedge clk);
        run(2);

        checks++;
        if (!wrap_seen_b) begin
            errors++;
            $display("FAIL frame_cnt_wrap actual=%0d required=1", wrap_seen_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_pattern_gen.md
# hdmi_pattern_gen

Video source that produces 1080p60 raster timing (vs/hs/de) and 24-bit RGB test patterns on the pixel clock. It drives the `vs_in`/`hs_in`/`de_in`/`r_in`/`g_in`/`b_in` inputs of the HDMI processing loop when no live HDMI receiver is present, or during bring-up. It is the transmitter side of the same parallel-video interface the loop consumes.

## Interface
- `X_WIDTH`, 12, width of horizontal counter and `x_act`
- `Y_WIDTH`, 12, width of vertical counter and `y_act`
- `H_TOTAL`, 2200, pixel clocks per line
- `H_SYNC`, 44, hsync width
- `H_BP`, 148, horizontal back porch
- `H_ACT`, 1920, active pixels per line; must be divisible by 8
- `H_FP`, 88, horizontal front porch; `H_SYNC+H_BP+H_ACT+H_FP == H_TOTAL`
- `V_TOTAL`, 1125, lines per frame
- `V_SYNC`, 5, vsync width in lines
- `V_BP`, 36, vertical back porch
- `V_ACT`, 1080, active lines
- `V_FP`, 4, vertical front porch; the four terms sum to `V_TOTAL`

Ports:
- `clk`  in  1  pixel clock (148.5 MHz at 1080p)
- `rst_n`  in  1  synchronous active-low reset
- `en`  in  1  generator enable
- `pattern_sel`  in  2  0 colour bars, 1 gray ramp, 2 grid, 3 flashing solid
- `vs_out`  out  1  vertical sync, active high
- `hs_out`  out  1  horizontal sync, active high
- `de_out`  out  1  active-video strobe
- `r_out`, `g_out`, `b_out`  out  8 each  pixel colour
- `x_act`  out  X_WIDTH  active-area column of the current `de_out` pixel; 0 outside active video
- `y_act`  out  Y_WIDTH  active-area row; 0 outside active video
- `frame_start`  out  1  one-cycle pulse, coincident with the first `vs_out` high cycle of each frame

## Operation
- Counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1). `h_cnt` wraps to 0 at H_TOTAL-1. `v_cnt` increments on the `h_cnt` wrap and wraps to 0 at V_TOTAL-1.
- Line order is sync, back porch, active, front porch. The frame uses the same order.
- hs = `h_cnt < H_SYNC`. vs = `v_cnt < V_SYNC`.
- de = `h_cnt` in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and `v_cnt` in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
- x = `h_cnt-(H_SYNC+H_BP)` and y = `v_cnt-(V_SYNC+V_BP)`. Both are valid only when de = 1.
- `pattern_sel` is latched into `pat_q` only when `h_cnt==0 && v_cnt==0`. A change mid-frame takes effect at the next frame.
- `frame_cnt` is 8 bits. It increments when `h_cnt==0 && v_cnt==0` and wraps 255→0.
- Patterns, applied when de = 1:
  - Pattern 0: eight bars, bar index = x/(H_ACT/8). Colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Pattern 1: r = g = b = x[10:3], truncated to 8 bits.
  - Pattern 2: white when `x[5:0]==0` or `y[5:0]==0`, otherwise black.
  - Pattern 3: r = `frame_cnt`, g = `~frame_cnt`, b = 8'h80.
- When de = 0, RGB = 0.
- `en` = 0: counters held at 0, and all outputs forced to 0 on the next edge. When `en` rises, counting starts at `h_cnt = v_cnt = 0`, so a frame begins immediately.
- Reset (`rst_n` = 0 at a rising edge), including mid-frame:
  - `h_cnt`, `v_cnt`, `frame_cnt` and all outputs go to 0.
  - `pat_q` goes to 0 (colour bars).

## Timing
- All outputs are registered. Outputs at edge n+1 reflect the counter values present at edge n (latency 1 cycle).
- vs, hs, de, RGB, `x_act`, `y_act` and `frame_start` are mutually aligned. There is no skew between sync and data.
- First cycle with `rst_n` = 1 and `en` = 1: counters = (0,0). One cycle later:
  - `vs_out` = `hs_out` = 1 and `frame_start` = 1.
  - `pat_q` is loaded in this same cycle.
- Per line: `hs_out` high for H_SYNC cycles. `de_out` high for H_ACT consecutive cycles, starting H_SYNC+H_BP cycles after the `hs_out` rise.
- Per frame: `vs_out` high for V_SYNC×H_TOTAL cycles. `de_out` is high on exactly V_ACT lines.
- Frame period is exactly H_TOTAL×V_TOTAL cycles (2,475,000 at defaults).
- `en` or `rst_n` deassertion mid-line: outputs are 0 on the next cycle. There is no partial-line completion.

## Test plan
- Reset: hold `rst_n` = 0 for 5 cycles with `en` = 1 → all outputs 0 every cycle. After release, `vs_out`, `hs_out` and `frame_start` go to 1 exactly 1 cycle later.
- Default timing: run 2 frames → per line, `hs_out` high 44 cycles and `de_out` high 1920 consecutive cycles starting 192 cycles after the hs rise. `de_out` is high 2,073,600 cycles per frame. The `frame_start` interval is 2,475,000 cycles.
- Colour bars (`pattern_sel` = 0): first de pixel of a line = FF/FF/FF at x = 0. x = 240 → FF/FF/00. x = 1919 → 00/00/00. During blanking, RGB = 0.
- Pattern switch: set `pattern_sel` = 1 at line 500 of frame 0 → frame 0 stays colour bars. Frame 1 at x = 800 gives r = g = b = 100.
- Flashing solid: `pattern_sel` = 3 for 3 frames → the b value is constant 0x80. The r value matches `frame_cnt`, which increments by 1 per frame, with g = ~r. Force 256 frames using small parameters (H_TOTAL = 20, H_SYNC = 2, H_BP = 2, H_ACT = 8, H_FP = 8, V_TOTAL = 10, V_SYNC = 1, V_BP = 1, V_ACT = 4, V_FP = 4) → r wraps 255→0.
- Mid-frame abort: drop `en` at `v_cnt` = 600 → all outputs 0 the next cycle. Raise `en` again → `frame_start` 1 cycle later and a full-length frame follows. Repeat using `rst_n` instead of `en` → same result, and `pat_q` returns to colour bars.
